junction_phase_scheduler: RTL and testbench

- Synthesizable, tick-timed scheduler for an N-approach junction. Grants green to exactly one approach at a time.
- Arbitrates vehicle-detector requests round-robin, with emergency preemption.
- Enforces min/max green, yellow and all-red clearance intervals, counted in time-base ticks rather than simulation waits.
- Sits between the detector/emergency inputs and the lamp drivers; replaces fixed two-road sequencing.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/junction_phase_scheduler.sv | 161 ++++++++++++++++
 tb/tb_junction_phase_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encoding and index-width helper for the junction scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'b00,
        LAMP_YELLOW = 2'b01,
        LAMP_GREEN  = 2'b10
    } lamp_t;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    // At least one bit, so a two-approach junction still gets a usable index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin: picks the first set request strictly after ptr, with wrap.
module rr_arbiter
    import traffic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic [idx_width(N)-1:0]   grant,
    output logic                      grant_valid
);

    localparam int IW = idx_width(N);

    int best_d;
    int d;

    // Distance 0 is the approach right after ptr; the pointer itself is distance N-1.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        best_d      = N;
        d           = 0;
        for (int i = 0; i < N; i++) begin
            d = (i + 2 * N - int'(ptr) - 1) % N;
            if (req[i] && (d < best_d)) begin
                best_d      = d;
                grant       = IW'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Tick-timed GREEN/YELLOW/ALLRED phase controller for an N-approach junction with
// round-robin detector arbitration and emergency preemption.
module junction_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APP     = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [N_APP-1:0]              req,
    input  logic                          emg_valid,
    input  logic [idx_width(N_APP)-1:0]   emg_id,
    output logic [2*N_APP-1:0]            lights,
    output logic [idx_width(N_APP)-1:0]   active_id,
    output logic                          green_start
);

    localparam int IW    = idx_width(N_APP);
    localparam int T_GY  = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
    localparam int T_MAX = (T_GY > ALLRED_T) ? T_GY : ALLRED_T;
    localparam int EW    = $clog2(T_MAX + 1);

    localparam logic [EW-1:0] MIN_C    = EW'(MIN_GREEN);
    localparam logic [EW-1:0] MAX_C    = EW'(MAX_GREEN);
    localparam logic [EW-1:0] YEL_C    = EW'(YELLOW_T);
    localparam logic [EW-1:0] AR_C     = EW'(ALLRED_T);
    localparam logic [IW:0]   N_LIM    = (IW + 1)'(N_APP);
    localparam logic [IW-1:0] PTR_INIT = IW'(N_APP - 1);

    // Phase register is kept as a plainly named signal so checkers can bind to it.
    phase_t          state;
    logic [EW-1:0]   elapsed;
    logic [IW-1:0]   ptr;

    logic [IW-1:0]   arb_grant;
    logic            arb_valid;
    logic            emg_ok;
    logic            emg_hold;
    logic [N_APP-1:0] other_vec;
    logic            other_req;
    logic            allred_done;
    logic            preempt;
    logic            gap_out;
    logic            max_out;
    logic [IW-1:0]   winner;
    logic [N_APP-1:0] lit;

    // A limit counts as reached when the tick arriving this cycle completes it,
    // so every interval lasts exactly its tick count.
    function automatic logic reached(input logic [EW-1:0] el, input logic tk,
                                     input logic [EW-1:0] lim);
        return (el >= lim) || (tk && (el == lim - 1'b1));
    endfunction

    function automatic logic [2*N_APP-1:0] lamp_vec(input logic [IW-1:0] id, input lamp_t code);
        logic [2*N_APP-1:0] v;
        v = '0;
        for (int i = 0; i < N_APP; i++) begin
            v[2*i +: 2] = (IW'(i) == id) ? code : LAMP_RED;
        end
        return v;
    endfunction

    rr_arbiter #(.N(N_APP)) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // emg_valid is a level request with no ready: it is honoured on any cycle it is
    // high with an in-range emg_id and simply ignored otherwise.
    always_comb begin
        emg_ok   = emg_valid && ({1'b0, emg_id} < N_LIM);
        emg_hold = emg_ok && (emg_id == active_id);
        for (int i = 0; i < N_APP; i++) begin
            other_vec[i] = req[i] && (IW'(i) != active_id);
        end
        other_req   = |other_vec;
        allred_done = reached(elapsed, tick, AR_C);
        preempt     = emg_ok && (emg_id != active_id);
        gap_out     = reached(elapsed, tick, MIN_C) && !req[active_id] && other_req;
        max_out     = reached(elapsed, tick, MAX_C) && other_req && !emg_hold;
        winner      = emg_ok ? emg_id : arb_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PH_ALLRED;
            elapsed     <= '0;
            ptr         <= PTR_INIT;
            active_id   <= '0;
            lights      <= '0;
            green_start <= 1'b0;
        end else begin
            green_start <= 1'b0;
            case (state)
                PH_ALLRED: begin
                    if (allred_done && (emg_ok || arb_valid)) begin
                        state       <= PH_GREEN;
                        elapsed     <= '0;
                        active_id   <= winner;
                        ptr         <= winner;
                        lights      <= lamp_vec(winner, LAMP_GREEN);
                        green_start <= 1'b1;
                    end else if (tick && (elapsed < AR_C)) begin
                        elapsed <= elapsed + 1'b1;
                    end
                end
                PH_GREEN: begin
                    if (preempt || gap_out || max_out) begin
                        state   <= PH_YELLOW;
                        elapsed <= '0;
                        lights  <= lamp_vec(active_id, LAMP_YELLOW);
                    end else if (tick && (elapsed < MAX_C)) begin
                        elapsed <= elapsed + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (tick && (elapsed == YEL_C - 1'b1)) begin
                        state   <= PH_ALLRED;
                        elapsed <= '0;
                        lights  <= '0;
                    end else if (tick) begin
                        elapsed <= elapsed + 1'b1;
                    end
                end
                default: begin
                    state   <= PH_ALLRED;
                    elapsed <= '0;
                    lights  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_APP; i++) begin
            lit[i] = (lights[2*i +: 2] != LAMP_RED);
        end
    end

    a_one_lamp: assert property (@(posedge clk) disable iff (rst) $countones(lit) <= 1);

    a_green_from_allred: assert property (@(posedge clk) disable iff (rst)
        green_start |-> $past(state) == PH_ALLRED);

    a_allred_from_yellow: assert property (@(posedge clk) disable iff (rst)
        (state == PH_ALLRED && $past(state) != PH_ALLRED && !$past(rst))
            |-> $past(state) == PH_YELLOW);

    a_yellow_from_green: assert property (@(posedge clk) disable iff (rst)
        (state == PH_YELLOW && $past(state) != PH_YELLOW && !$past(rst))
            |-> $past(state) == PH_GREEN);

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Scenario bench for junction_phase_scheduler: grant order scored from a queue,
// phase durations and lamp codes checked inline per scenario.
module tb_junction_phase_scheduler;

    localparam int N  = 5;
    localparam int IW = 3;
    localparam int LW = 2 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [N-1:0]  req;
    logic          emg_valid;
    logic [IW-1:0] emg_id;
    logic [LW-1:0] lights;
    logic [IW-1:0] active_id;
    logic          green_start;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [IW-1:0] exp_q[$];
    logic          mon_en   = 1'b0;
    logic          sparse   = 1'b0;
    int            cyc_n    = 0;

    always #5 clk = ~clk;

    junction_phase_scheduler #(.N_APP(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req         (req),
        .emg_valid   (emg_valid),
        .emg_id      (emg_id),
        .lights      (lights),
        .active_id   (active_id),
        .green_start (green_start)
    );

    // Scoreboard: every green_start must match the next queued approach.
    always @(posedge clk) begin
        #2;
        if (mon_en && green_start) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_order: got grant to %0d, expected no grant", active_id);
            end else begin
                logic [IW-1:0] e;
                e = exp_q.pop_front();
                if (active_id !== e) begin
                    n_fail++;
                    $display("FAIL grant_order: got %0d expected %0d", active_id, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next();
        @(posedge clk);
        #1;
        cyc_n++;
        tick = sparse ? (cyc_n % 4 == 0) : 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sparse    = 1'b0;
        emg_valid = 1'b0;
        emg_id    = '0;
        req       = '0;
        next();
        next();
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    function automatic logic lamp_is(input int app, input logic [1:0] code);
        if (app < 0) return lights == '0;
        return lights[2*app +: 2] == code;
    endfunction

    // Counts consecutive cycles (from the current one) with the lamp condition true.
    task automatic count_state(input int app, input logic [1:0] code, input int limit,
                               output int n, output int nt);
        n  = 0;
        nt = 0;
        while (n < limit && lamp_is(app, code)) begin
            n++;
            if (tick) nt++;
            next();
        end
    endtask

    task automatic wait_grant(input int limit, output int w);
        w = 0;
        while (!green_start && w < limit) begin
            next();
            w++;
        end
        if (!green_start) w = -1;
    endtask

    task automatic end_test(input string name);
        next();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d grants outstanding expected 0", name, exp_q.size());
        end
        mon_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        n_checks++;
        if (lights !== '0 || active_id !== '0 || green_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lights=%b id=%0d gs=%b expected 0/0/0",
                     lights, active_id, green_start);
        end
        req = 5'b00001;
        exp_q.push_back(IW'(0));
        next();
        n_checks++;
        if (lights !== '0) begin
            n_fail++;
            $display("FAIL reset_allred_c1: got %b expected all red", lights);
        end
        next();
        n_checks++;
        if (lights !== LW'(2) || active_id !== '0 || green_start !== 1'b1) begin
            n_fail++;
            $display("FAIL first_green_c2: got lights=%b id=%0d gs=%b expected %b/0/1",
                     lights, active_id, green_start, LW'(2));
        end
        bad = 0;
        repeat (20) begin
            next();
            if (lights !== LW'(2) || green_start !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rest_in_green: got %0d bad cycles expected 0", bad);
        end
        end_test("reset");
    endtask

    task automatic test_max_out();
        int w, n, nt;
        do_reset();
        req = 5'b00101;
        exp_q.push_back(IW'(0));
        exp_q.push_back(IW'(2));
        exp_q.push_back(IW'(0));
        wait_grant(10, w);
        n_checks++;
        if (w != 2) begin n_fail++; $display("FAIL maxout_first_grant: got %0d expected 2", w); end
        for (int k = 0; k < 2; k++) begin
            count_state(2 * k, 2'b10, 40, n, nt);
            n_checks++;
            if (n != 8) begin n_fail++; $display("FAIL maxout_green_%0d: got %0d expected 8", 2 * k, n); end
            count_state(2 * k, 2'b01, 40, n, nt);
            n_checks++;
            if (n != 3) begin n_fail++; $display("FAIL maxout_yellow_%0d: got %0d expected 3", 2 * k, n); end
            count_state(-1, 2'b00, 40, n, nt);
            n_checks++;
            if (n != 2) begin n_fail++; $display("FAIL maxout_allred_%0d: got %0d expected 2", 2 * k, n); end
        end
        n_checks++;
        if (lights !== LW'(2)) begin
            n_fail++;
            $display("FAIL maxout_back_to_0: got %b expected %b", lights, LW'(2));
        end
        end_test("max_out");
    endtask

    task automatic test_gap_out();
        int w, n, nt;
        do_reset();
        req = 5'b00011;
        exp_q.push_back(IW'(0));
        wait_grant(10, w);
        next();
        req = 5'b00010;
        count_state(0, 2'b10, 40, n, nt);
        n_checks++;
        if (n != 3) begin n_fail++; $display("FAIL gap_min_green: got %0d more cycles expected 3", n); end
        n_checks++;
        if (lights !== LW'(1)) begin n_fail++; $display("FAIL gap_yellow: got %b expected %b", lights, LW'(1)); end
        exp_q.push_back(IW'(1));
        wait_grant(20, w);
        n_checks++;
        if (w != 5) begin n_fail++; $display("FAIL gap_clearance: got %0d expected 5", w); end
        req = 5'b00011;
        repeat (6) next();
        n_checks++;
        if (lights !== LW'(2 << 2)) begin n_fail++; $display("FAIL gap_hold_e6: got %b expected %b", lights, LW'(2 << 2)); end
        req = 5'b00001;
        exp_q.push_back(IW'(0));
        next();
        n_checks++;
        if (lights !== LW'(1 << 2)) begin n_fail++; $display("FAIL gap_late_drop: got %b expected %b", lights, LW'(1 << 2)); end
        wait_grant(20, w);
        n_checks++;
        if (w != 5) begin n_fail++; $display("FAIL gap_regrant: got %0d expected 5", w); end
        end_test("gap_out");
    endtask

    task automatic test_round_robin();
        int w, n, nt;
        do_reset();
        req = 5'b01111;
        exp_q.push_back(IW'(0));
        exp_q.push_back(IW'(1));
        exp_q.push_back(IW'(2));
        exp_q.push_back(IW'(3));
        exp_q.push_back(IW'(0));
        wait_grant(10, w);
        for (int k = 0; k < 4; k++) begin
            count_state(k, 2'b10, 40, n, nt);
            n_checks++;
            if (n != 8) begin n_fail++; $display("FAIL rr_green_%0d: got %0d expected 8", k, n); end
            wait_grant(20, w);
            n_checks++;
            if (w != 5) begin n_fail++; $display("FAIL rr_gap_%0d: got %0d expected 5", k, w); end
        end
        end_test("round_robin");
    endtask

    task automatic test_emergency();
        int w, n, nt, bad;
        do_reset();
        req = 5'b00011;
        exp_q.push_back(IW'(0));
        wait_grant(10, w);
        next();
        emg_valid = 1'b1;
        emg_id    = IW'(3);
        exp_q.push_back(IW'(3));
        next();
        n_checks++;
        if (lights !== LW'(1)) begin n_fail++; $display("FAIL emg_preempt: got %b expected %b", lights, LW'(1)); end
        count_state(0, 2'b01, 40, n, nt);
        count_state(-1, 2'b00, 40, n, nt);
        n_checks++;
        if (n != 2) begin n_fail++; $display("FAIL emg_allred: got %0d expected 2", n); end
        n_checks++;
        if (lights !== LW'(2 << 6) || active_id !== IW'(3)) begin
            n_fail++;
            $display("FAIL emg_grant: got lights=%b id=%0d expected %b/3", lights, active_id, LW'(2 << 6));
        end
        req = 5'b01111;
        bad = 0;
        repeat (12) begin
            next();
            if (lights !== LW'(2 << 6)) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL emg_no_maxout: got %0d bad cycles expected 0", bad); end
        emg_id = IW'(5);
        exp_q.push_back(IW'(0));
        next();
        n_checks++;
        if (lights !== LW'(1 << 6)) begin n_fail++; $display("FAIL emg_bad_id: got %b expected %b", lights, LW'(1 << 6)); end
        wait_grant(20, w);
        n_checks++;
        if (w != 5) begin n_fail++; $display("FAIL emg_bad_id_regrant: got %0d expected 5", w); end
        emg_valid = 1'b0;
        end_test("emergency");
    endtask

    task automatic test_sparse_tick_reset();
        int w, n, nt;
        do_reset();
        req = 5'b00011;
        exp_q.push_back(IW'(0));
        wait_grant(10, w);
        sparse = 1'b1;
        count_state(0, 2'b10, 200, n, nt);
        count_state(0, 2'b01, 100, n, nt);
        n_checks++;
        if (n != 12 || nt != 3) begin
            n_fail++;
            $display("FAIL sparse_yellow: got %0d cycles %0d ticks expected 12/3", n, nt);
        end
        exp_q.push_back(IW'(1));
        count_state(-1, 2'b00, 100, n, nt);
        n_checks++;
        if (nt != 2) begin n_fail++; $display("FAIL sparse_allred: got %0d ticks expected 2", nt); end
        count_state(1, 2'b10, 200, n, nt);
        next();
        n_checks++;
        if (lights !== LW'(1 << 2)) begin n_fail++; $display("FAIL sparse_mid_yellow: got %b expected %b", lights, LW'(1 << 2)); end
        rst = 1'b1;
        next();
        n_checks++;
        if (lights !== '0 || active_id !== '0 || green_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_yellow: got lights=%b id=%0d gs=%b expected 0/0/0",
                     lights, active_id, green_start);
        end
        rst = 1'b0;
        exp_q.push_back(IW'(0));
        count_state(-1, 2'b00, 100, n, nt);
        n_checks++;
        if (nt != 2 || lights !== LW'(2)) begin
            n_fail++;
            $display("FAIL reset_allred: got %0d ticks lights=%b expected 2/%b", nt, lights, LW'(2));
        end
        sparse = 1'b0;
        end_test("sparse_reset");
    endtask

    initial begin
        rst       = 1'b1;
        tick      = 1'b1;
        req       = '0;
        emg_valid = 1'b0;
        emg_id    = '0;
        test_reset();
        test_max_out();
        test_gap_out();
        test_round_robin();
        test_emergency();
        test_sparse_tick_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
